speck_request_arbiter: RTL
==========================

Name: speck_request_arbiter

Overview:
Shares one `encrypt` core between NUM_REQ independent requesters using round-robin arbitration. The block latches the granted requester's plaintext and key, then drives the core's start/finished handshake. It returns the ciphertext, or a timeout error, to that requester only. It sits between the system-side request ports and a single `encrypt` instance.

Parameters:
NUM_REQ, 4, number of requester ports (2..16)
DATA_W, 128, plaintext/key/ciphertext width (matches `KEY_SIZE)
TIMEOUT_CYCLES, 1024, maximum cycles to wait for core_finished after core_start

Ports:
clk  in  1  single system clock, all logic on posedge
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request; held high, with operands stable, until req_ready
req_ready  out  NUM_REQ  one-hot accept, combinational, asserted only in IDLE
req_plaintext  in  NUM_REQ*DATA_W  packed; requester i occupies bits [i*DATA_W +: DATA_W]
req_key  in  NUM_REQ*DATA_W  packed, same layout
rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe, registered
rsp_ciphertext  out  DATA_W  result; valid only while any rsp_valid bit is high
rsp_error  out  1  high with rsp_valid when the request timed out
core_start  out  1  one-cycle start pulse to `encrypt`
core_finished  in  1  finished pulse from `encrypt`
core_plaintext  out  DATA_W  latched operand to core, stable from LAUNCH through WAIT
core_key  out  DATA_W  latched operand to core, stable from LAUNCH through WAIT
core_ciphertext  in  DATA_W  core result, sampled in the cycle core_finished=1
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, rst=1 at a posedge) forces the following, regardless of state:
  - state=IDLE, rr_ptr=0, grant=0, timer=0
  - core_start=0, rsp_valid=0, rsp_error=0, rsp_ciphertext=0
  - core_plaintext=0, core_key=0
- State machine (registered): IDLE -> LAUNCH -> WAIT -> RESPOND -> IDLE.
- IDLE:
  - sel = first index j scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ with req_valid[j]=1.
  - req_ready[sel]=1 only if some req_valid is set; all other bits 0.
  - On that cycle: latch operands of sel into core_plaintext/core_key, grant<=sel, go to LAUNCH.
  - No request: stay in IDLE, all req_ready=0.
- LAUNCH: core_start=1 for exactly this cycle; timer<=0; go to WAIT.
- WAIT:
  - core_start=0.
  - core_finished=1: latch core_ciphertext into rsp_ciphertext, rsp_error<=0, go to RESPOND.
  - Else if timer==TIMEOUT_CYCLES-1: rsp_ciphertext<=0, rsp_error<=1, go to RESPOND.
  - Else timer<=timer+1.
  - core_finished takes priority if it coincides with the timeout cycle.
- RESPOND:
  - rsp_valid[grant]=1 for one cycle.
  - rr_ptr<=(grant+1) mod NUM_REQ.
  - Go to IDLE; rsp_valid and rsp_error clear on the next cycle.
- Latency:
  - Accept at cycle T; core_start at T+1.
  - If core_finished at cycle F, rsp_valid at F+1.
  - Earliest re-accept is F+2; the back-to-back gap between accepts is core latency + 3 cycles.
- core_finished outside WAIT is ignored, including a late pulse after a timeout or after reset.
- req_valid dropping before grant is legal: the request is simply not selected.
- Operands are captured once; requester changes after accept have no effect.
- rr_ptr advances only on completion (success or error). Fairness: a continuously valid requester is served within NUM_REQ grants.
- Reset in LAUNCH/WAIT/RESPOND aborts the operation; no rsp_valid is emitted for it.
- timer width = clog2(TIMEOUT_CYCLES)+1; it never wraps.

Test Plan:
- Bench stub core: asserts core_finished 10 cycles after core_start, with core_ciphertext = plaintext ^ key.
- Single request: req_valid[2]=1, pt=128'h11, key=128'h22 -> req_ready[2] same cycle, core_start next cycle, rsp_valid=4'b0100 with rsp_ciphertext=128'h33, rsp_error=0, 12 cycles after accept.
- All four requesters valid from reset -> grant order 0,1,2,3,0; each response one-hot on the matching rsp_valid bit; busy=1 continuously except single IDLE cycles.
- Stub never finishes, TIMEOUT_CYCLES=16 -> rsp_valid at accept+18, rsp_error=1, rsp_ciphertext=0. A late core_finished afterwards produces no rsp_valid.
- rst=1 for one cycle at WAIT timer=5 -> next cycle busy=0, core_start=0, rr_ptr=0. The stub's subsequent finished pulse is ignored and no response is emitted.
- core_finished pulsed while IDLE with no requests -> no state change, rsp_valid stays 0.
- finished coinciding with timer==TIMEOUT_CYCLES-1 -> rsp_error=0 and the real ciphertext is returned.

Source files
------------

// File: rtl/speck_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : speck_request_arbiter
//  Description : Shares a single `encrypt` core between NUM_REQ requesters.
//                Requesters are picked round-robin. The granted requester's
//                plaintext and key are latched and handed to the core through
//                a start/finished handshake. The ciphertext, or a timeout
//                error, is returned to that requester only.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             system clock, all logic on the rising edge
//    rst             synchronous active-high reset
//    req_valid       per-requester request; operands held stable until ready
//    req_ready       one-hot accept strobe, combinational, only in IDLE
//    req_plaintext   packed plaintexts, requester i at [i*DATA_W +: DATA_W]
//    req_key         packed keys, same layout as req_plaintext
//    rsp_valid       one-hot, one-cycle response strobe to the granted port
//    rsp_ciphertext  result, meaningful only while rsp_valid is non-zero
//    rsp_error       set together with rsp_valid when the core timed out
//    core_start      one-cycle start pulse to the core
//    core_finished   completion pulse from the core
//    core_plaintext  latched plaintext operand to the core
//    core_key        latched key operand to the core
//    core_ciphertext core result, sampled when core_finished is high
//    busy            high whenever the arbiter is not idle
// ============================================================================
module speck_request_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_plaintext,
  input  logic [NUM_REQ*DATA_W-1:0]   req_key,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_ciphertext,
  output logic                        rsp_error,
  output logic                        core_start,
  input  logic                        core_finished,
  output logic [DATA_W-1:0]           core_plaintext,
  output logic [DATA_W-1:0]           core_key,
  input  logic [DATA_W-1:0]           core_ciphertext,
  output logic                        busy
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  // One spare bit so the counter can never wrap before the limit is hit.
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant;
  logic [TIMER_W-1:0] timer;

  logic [IDX_W-1:0]   sel;
  logic               found;
  logic [NUM_REQ-1:0] grant_onehot;
  logic [IDX_W-1:0]   next_ptr;

  // --------------------------------------------------------------------------
  // Round-robin pick. The scan runs from the farthest offset back to rr_ptr so
  // the last hit, which is the one kept, is the closest valid requester at or
  // after rr_ptr.
  // --------------------------------------------------------------------------
  always_comb begin
    logic [IDX_W-1:0] cand;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_IDLE && found) begin
      req_ready[sel] = 1'b1;
    end
  end

  always_comb begin
    grant_onehot        = '0;
    grant_onehot[grant] = 1'b1;
  end

  assign next_ptr = (grant == IDX_LAST) ? '0 : grant + 1'b1;
  assign busy     = (state != ST_IDLE);

  // --------------------------------------------------------------------------
  // Control FSM. All outputs other than req_ready and busy are registered, so
  // core_start is raised on the IDLE->LAUNCH transition and rsp_valid on the
  // WAIT->RESPOND transition to line up with the LAUNCH and RESPOND cycles.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      grant          <= '0;
      timer          <= '0;
      core_start     <= 1'b0;
      rsp_valid      <= '0;
      rsp_error      <= 1'b0;
      rsp_ciphertext <= '0;
      core_plaintext <= '0;
      core_key       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            core_plaintext <= req_plaintext[int'(sel)*DATA_W +: DATA_W];
            core_key       <= req_key[int'(sel)*DATA_W +: DATA_W];
            grant          <= sel;
            core_start     <= 1'b1;
            state          <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          core_start <= 1'b0;
          timer      <= '0;
          state      <= ST_WAIT;
        end

        ST_WAIT: begin
          // A finished pulse on the final timer cycle still counts as success.
          if (core_finished) begin
            rsp_ciphertext <= core_ciphertext;
            rsp_error      <= 1'b0;
            rsp_valid      <= grant_onehot;
            state          <= ST_RESPOND;
          end else if (timer == TIMER_LAST) begin
            rsp_ciphertext <= '0;
            rsp_error      <= 1'b1;
            rsp_valid      <= grant_onehot;
            state          <= ST_RESPOND;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_RESPOND: begin
          rsp_valid <= '0;
          rsp_error <= 1'b0;
          rr_ptr    <= next_ptr;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
